// File: rtl/lvds_link_pkg.sv
// rtl/lvds_link_pkg.sv - shared LVDS link definitions for the transmit and receive framers
//
// Holds the link FSM state encoding, the default training and sync patterns,
// and the fill-word definition used on both ends of the inter-FPGA channel.
package lvds_link_pkg;

    // Encoded on state_out for LEDs/debug; values are fixed so both framers agree.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRAIN = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3
    } link_state_t;

    localparam logic [7:0] TRAIN_PAT_DEFAULT = 8'h35;
    localparam logic [7:0] SYNC_PAT_DEFAULT  = 8'h77;

    // A fill word is every bit equal to FILL_BIT. The receiver classifies a
    // word by its MSB, so real data must always carry MSB = ~FILL_BIT.
    localparam logic FILL_BIT = 1'b0;

endpackage

// File: rtl/lvds_word_slicer.sv
// rtl/lvds_word_slicer.sv - word shift register that hands out SER_W-bit beats MSB first
//
// Ports:
//   tx_inclock    in   clock, rising edge
//   reset_n       in   synchronous active-low reset
//   clear_i       in   drop any partial word, beat counter back to 0
//   load_i        in   capture word_i at a word boundary (beat 0)
//   shift_i       in   advance one beat (shift left by SER_W)
//   word_i        in   WORD_W word to load
//   next_slice_o  out  slice that becomes the beat after the current one
//   last_beat_o   out  current beat is the last of the word slot
module lvds_word_slicer #(
    parameter int WORD_W = 32,
    parameter int SER_W  = 8
) (
    input  logic              tx_inclock,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [SER_W-1:0]  next_slice_o,
    output logic              last_beat_o
);

    localparam int BEATS  = WORD_W / SER_W;
    localparam int BEAT_W = $clog2(BEATS);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    always_comb begin
        shift_d = shift_q;
        beat_d  = beat_q;
        if (clear_i) begin
            shift_d = '0;
            beat_d  = '0;
        end else if (load_i) begin
            shift_d = word_i;
            beat_d  = '0;
        end else if (shift_i) begin
            shift_d = shift_q << SER_W;
            beat_d  = beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge tx_inclock) begin
        if (!reset_n) begin
            shift_q <= '0;
            beat_q  <= '0;
        end else begin
            shift_q <= shift_d;
            beat_q  <= beat_d;
        end
    end

    // The MSB slice of shift_q is the beat on the wire now; the one below it is next.
    assign next_slice_o = shift_q[WORD_W-SER_W-1 -: SER_W];
    assign last_beat_o  = (beat_q == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/lvds_tx_framer.sv
// rtl/lvds_tx_framer.sv - LVDS transmit framer: training, sync markers, word slicing, fill
//
// Ports:
//   tx_inclock     in   serializer parallel clock, rising edge
//   reset_n        in   synchronous active-low reset
//   tx_locked      in   serializer PLL lock; low forces IDLE
//   rdy_from_recv  in   far end aligned and accepting words
//   src_data       in   show-ahead FIFO head word
//   src_rdy        in   FIFO non-empty
//   src_en         out  one-cycle dequeue strobe, coincident with the MSB beat
//   tx_in          out  SER_W beat to the serializer
//   link_up        out  high in SYNC and DATA
//   state_out      out  encoded FSM state
//   words_sent     out  data words popped, wraps
module lvds_tx_framer
    import lvds_link_pkg::*;
#(
    parameter int                WORD_W        = 32,
    parameter int                SER_W         = 8,
    parameter logic [SER_W-1:0]  TRAIN_PAT     = SER_W'(TRAIN_PAT_DEFAULT),
    parameter logic [SER_W-1:0]  SYNC_PAT      = SER_W'(SYNC_PAT_DEFAULT),
    parameter int                RESYNC_PERIOD = 1024,
    parameter int                LOSS_WORDS    = 4,
    parameter int                CNT_W         = 16
) (
    input  logic              tx_inclock,
    input  logic              reset_n,
    input  logic              tx_locked,
    input  logic              rdy_from_recv,
    input  logic [WORD_W-1:0] src_data,
    input  logic              src_rdy,
    output logic              src_en,
    output logic [SER_W-1:0]  tx_in,
    output logic              link_up,
    output logic [2:0]        state_out,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int RS_W = (RESYNC_PERIOD > 0) ? $clog2(RESYNC_PERIOD + 1) : 1;

    link_state_t       state_q, state_d;
    logic [SER_W-1:0]  tx_in_q, tx_in_d;
    logic              src_en_q, src_en_d;
    logic              link_up_q, link_up_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [RS_W-1:0]   resync_q, resync_d;
    logic [7:0]        loss_q, loss_d;
    logic              loss_exit_q, loss_exit_d;
    logic              resync_beat_q, resync_beat_d;

    logic              sl_clear, sl_load, sl_shift;
    logic [WORD_W-1:0] sl_word;
    logic [SER_W-1:0]  next_slice;
    logic              last_beat;

    logic              boundary_next;
    logic              resync_due;

    lvds_word_slicer #(
        .WORD_W (WORD_W),
        .SER_W  (SER_W)
    ) u_slicer (
        .tx_inclock   (tx_inclock),
        .reset_n      (reset_n),
        .clear_i      (sl_clear),
        .load_i       (sl_load),
        .shift_i      (sl_shift),
        .word_i       (sl_word),
        .next_slice_o (next_slice),
        .last_beat_o  (last_beat)
    );

    // Outputs are registered for the cycle being entered, so every decision
    // below is taken at the edge that starts the affected beat. The cycle after
    // SYNC, after a resync beat, or after a slot's last beat is a word boundary.
    assign boundary_next = (state_q == ST_SYNC) ||
                           ((state_q == ST_DATA) && (resync_beat_q || last_beat));
    assign resync_due    = (RESYNC_PERIOD != 0) && (resync_q == RS_W'(RESYNC_PERIOD));

    always_ff @(posedge tx_inclock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!tx_locked) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_TRAIN;
                ST_TRAIN: if (rdy_from_recv) state_d = ST_SYNC;
                ST_SYNC:  state_d = ST_DATA;
                ST_DATA:  if (last_beat && !resync_beat_q && loss_exit_q) state_d = ST_TRAIN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_in_d       = '0;
        src_en_d      = 1'b0;
        link_up_d     = (state_d == ST_SYNC) || (state_d == ST_DATA);
        words_d       = words_q;
        resync_d      = resync_q;
        loss_d        = loss_q;
        loss_exit_d   = loss_exit_q;
        resync_beat_d = 1'b0;
        sl_clear      = 1'b0;
        sl_load       = 1'b0;
        sl_shift      = 1'b0;
        sl_word       = {WORD_W{FILL_BIT}};
        case (state_d)
            ST_IDLE: begin
                sl_clear = 1'b1;
            end
            ST_TRAIN: begin
                tx_in_d  = TRAIN_PAT;
                sl_clear = 1'b1;
            end
            ST_SYNC: begin
                tx_in_d     = SYNC_PAT;
                resync_d    = '0;
                loss_d      = '0;
                loss_exit_d = 1'b0;
            end
            ST_DATA: begin
                if (boundary_next) begin
                    if (resync_due) begin
                        // Marker beat only: no pop, no slot, counters other than resync untouched.
                        tx_in_d       = SYNC_PAT;
                        resync_d      = '0;
                        resync_beat_d = 1'b1;
                    end else begin
                        resync_d = resync_q + RS_W'(1);
                        sl_load  = 1'b1;
                        if (rdy_from_recv && src_rdy) begin
                            sl_word  = src_data;
                            tx_in_d  = src_data[WORD_W-1 -: SER_W];
                            src_en_d = 1'b1;
                            words_d  = words_q + CNT_W'(1);
                            loss_d   = '0;
                        end else begin
                            tx_in_d = {SER_W{FILL_BIT}};
                        end
                        if (!rdy_from_recv) begin
                            loss_d = loss_q + 8'd1;
                            if (loss_q + 8'd1 == 8'(LOSS_WORDS)) begin
                                loss_exit_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    sl_shift = 1'b1;
                    tx_in_d  = next_slice;
                end
            end
            default: begin
                sl_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge tx_inclock) begin
        if (!reset_n) begin
            tx_in_q       <= '0;
            src_en_q      <= 1'b0;
            link_up_q     <= 1'b0;
            words_q       <= '0;
            resync_q      <= '0;
            loss_q        <= '0;
            loss_exit_q   <= 1'b0;
            resync_beat_q <= 1'b0;
        end else begin
            tx_in_q       <= tx_in_d;
            src_en_q      <= src_en_d;
            link_up_q     <= link_up_d;
            words_q       <= words_d;
            resync_q      <= resync_d;
            loss_q        <= loss_d;
            loss_exit_q   <= loss_exit_d;
            resync_beat_q <= resync_beat_d;
        end
    end

    assign tx_in      = tx_in_q;
    assign src_en     = src_en_q;
    assign link_up    = link_up_q;
    assign state_out  = state_q;
    assign words_sent = words_q;

endmodule
